// File: rtl/seg7_pkg.sv
// Shared seven-segment constants and types for the scan driver and its decoder.
// Patterns are active-high, segment a in bit 6 down to g in bit 0.
package seg7_pkg;

  localparam int unsigned SEG_W = 7;
  localparam int unsigned BCD_W = 4;

  typedef logic [SEG_W-1:0] seg_t;
  typedef logic [BCD_W-1:0] bcd_t;

  localparam seg_t SEG_0     = 7'b1111110;
  localparam seg_t SEG_1     = 7'b0110000;
  localparam seg_t SEG_2     = 7'b1101101;
  localparam seg_t SEG_3     = 7'b1111001;
  localparam seg_t SEG_4     = 7'b0110011;
  localparam seg_t SEG_5     = 7'b1011011;
  localparam seg_t SEG_6     = 7'b1011111;
  localparam seg_t SEG_7     = 7'b1110000;
  localparam seg_t SEG_8     = 7'b1111111;
  localparam seg_t SEG_9     = 7'b1111011;
  localparam seg_t SEG_BLANK = 7'b0000000;

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Host-side data/strobe inputs and display-side outputs of the scan driver.
interface seg7_scan_driver_if #(
  parameter int unsigned NUM_DIGITS = 4
);
  import seg7_pkg::*;

  logic [4*NUM_DIGITS-1:0] bcd_in;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic                    load;
  logic                    blank_lz;
  seg_t                    seg;
  logic                    dp;
  logic [NUM_DIGITS-1:0]   an;
  logic                    frame_done;

  modport master (
    output bcd_in, dp_in, load, blank_lz,
    input  seg, dp, an, frame_done
  );

  modport slave (
    input  bcd_in, dp_in, load, blank_lz,
    output seg, dp, an, frame_done
  );

endinterface

// File: rtl/seg7_digit_decode.sv
// BCD to active-high seven-segment decoder; non-decimal codes are blank.
module seg7_digit_decode
  import seg7_pkg::*;
(
  input  bcd_t bcd,
  output seg_t seg_c
);

  always_comb begin
    seg_c = SEG_BLANK;
    case (bcd)
      4'd0:    seg_c = SEG_0;
      4'd1:    seg_c = SEG_1;
      4'd2:    seg_c = SEG_2;
      4'd3:    seg_c = SEG_3;
      4'd4:    seg_c = SEG_4;
      4'd5:    seg_c = SEG_5;
      4'd6:    seg_c = SEG_6;
      4'd7:    seg_c = SEG_7;
      4'd8:    seg_c = SEG_8;
      4'd9:    seg_c = SEG_9;
      default: seg_c = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed seven-segment display driver with frame-synchronous data update,
// per-slot dead time and optional leading-zero blanking.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned SCAN_DIV   = 1000,
  parameter int unsigned DEAD       = 2,
  parameter bit          ACTIVE_LOW = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  seg7_scan_driver_if.slave  bus
);

  localparam int unsigned DIV_W = $clog2(SCAN_DIV);
  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam seg_t                  SEG_POL = seg_t'(ACTIVE_LOW ? 7'h7F : 7'h00);
  localparam logic [NUM_DIGITS-1:0] AN_POL  = {NUM_DIGITS{ACTIVE_LOW}};

  logic [DIV_W-1:0] div;
  logic [IDX_W-1:0] idx;

  logic [NUM_DIGITS-1:0][BCD_W-1:0] shadow_bcd;
  logic [NUM_DIGITS-1:0][BCD_W-1:0] pend_bcd;
  logic [NUM_DIGITS-1:0]            shadow_dp;
  logic [NUM_DIGITS-1:0]            pend_dp;
  logic                             pend_flag;

  logic                  slot_end_c;
  logic                  frame_end_c;
  logic                  dead_c;
  logic                  blank_c;
  logic [NUM_DIGITS-1:0] lz_mask_c;
  bcd_t                  sel_bcd_c;
  seg_t                  raw_seg_c;
  seg_t                  lit_seg_c;

  assign slot_end_c  = (div == DIV_W'(SCAN_DIV - 1));
  assign frame_end_c = slot_end_c && (idx == IDX_W'(NUM_DIGITS - 1));
  assign dead_c      = (div < DIV_W'(DEAD));

  // Slot and digit position counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div <= '0;
      idx <= '0;
    end else if (slot_end_c) begin
      div <= '0;
      idx <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + IDX_W'(1);
    end else begin
      div <= div + DIV_W'(1);
    end
  end

  // Loads park in the pending buffer; the shown data only moves at the frame boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_bcd <= '0;
      shadow_dp  <= '0;
      pend_bcd   <= '0;
      pend_dp    <= '0;
      pend_flag  <= 1'b0;
    end else if (bus.load && frame_end_c) begin
      shadow_bcd <= bus.bcd_in;
      shadow_dp  <= bus.dp_in;
      pend_flag  <= 1'b0;
    end else if (bus.load) begin
      pend_bcd  <= bus.bcd_in;
      pend_dp   <= bus.dp_in;
      pend_flag <= 1'b1;
    end else if (frame_end_c && pend_flag) begin
      shadow_bcd <= pend_bcd;
      shadow_dp  <= pend_dp;
      pend_flag  <= 1'b0;
    end
  end

  // lz_mask_c[i] is set when shadow digits NUM_DIGITS-1 down to i are all zero.
  always_comb begin
    logic run;
    lz_mask_c = '0;
    run       = 1'b1;
    for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
      run          = run & (shadow_bcd[i] == 4'd0);
      lz_mask_c[i] = run;
    end
  end

  assign sel_bcd_c = shadow_bcd[idx];
  assign blank_c   = bus.blank_lz && (idx != '0) && lz_mask_c[idx];

  seg7_digit_decode u_decode (
    .bcd   (sel_bcd_c),
    .seg_c (raw_seg_c)
  );

  assign lit_seg_c = blank_c ? SEG_BLANK : raw_seg_c;

  // Registered drive stage; polarity applied after decode, everything dark in dead time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.seg        <= SEG_POL;
      bus.dp         <= ACTIVE_LOW;
      bus.an         <= AN_POL;
      bus.frame_done <= 1'b0;
    end else begin
      bus.frame_done <= frame_end_c;
      if (dead_c) begin
        bus.seg <= SEG_POL;
        bus.dp  <= ACTIVE_LOW;
        bus.an  <= AN_POL;
      end else begin
        bus.seg <= SEG_POL ^ lit_seg_c;
        bus.dp  <= ACTIVE_LOW ^ shadow_dp[idx];
        bus.an  <= AN_POL ^ (NUM_DIGITS'(1) << idx);
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: directed vector table, hand-written boundary/reset
// sequences and random loads, all checked against a frame-position reference model.
module tb_seg7_scan_driver;

  localparam int ND    = 4;
  localparam int SD    = 8;
  localparam int DD    = 2;
  localparam int FRAME = ND * SD;

  localparam logic [6:0] SEGTAB [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b0000000, 7'b0000000,
    7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000
  };

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seg7_scan_driver_if #(.NUM_DIGITS(ND)) bus0 ();
  seg7_scan_driver_if #(.NUM_DIGITS(ND)) bus1 ();

  seg7_scan_driver #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .DEAD(DD), .ACTIVE_LOW(1'b0)) dut_hi (
    .clk(clk), .rst_n(rst_n), .bus(bus0)
  );
  seg7_scan_driver #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .DEAD(DD), .ACTIVE_LOW(1'b1)) dut_lo (
    .clk(clk), .rst_n(rst_n), .bus(bus1)
  );

  typedef struct {
    logic [15:0]      bcd;
    logic [3:0]       dpv;
    logic             bl;
    logic [3:0][6:0]  segs;
    logic [3:0]       dps;
  } vec_t;

  vec_t tbl [6];

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: kn is the index of the next clock edge since reset release.
  int          kn;
  logic [15:0] m_shadow, m_pend;
  logic [3:0]  m_sdp, m_pdp;
  logic        m_pflag;
  logic        cur_bl;

  logic [6:0] obs_seg;
  logic       obs_dp;
  logic [3:0] obs_an;
  logic       obs_fd;

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    kn = 0; m_shadow = '0; m_pend = '0; m_sdp = '0; m_pdp = '0; m_pflag = 1'b0;
  endtask

  task automatic drive(input logic ld, input logic [15:0] b, input logic [3:0] d, input logic bl);
    bus0.load = ld; bus0.bcd_in = b; bus0.dp_in = d; bus0.blank_lz = bl;
    bus1.load = ld; bus1.bcd_in = b; bus1.dp_in = d; bus1.blank_lz = bl;
  endtask

  // One clock: drive inputs, predict outputs for this edge, advance, compare at negedge.
  task automatic cycle(input logic ld, input logic [15:0] b, input logic [3:0] d, input logic bl);
    int div, idx;
    logic [3:0] e_an, n_an;
    logic [6:0] e_seg, n_seg;
    logic       e_dp, n_dp, e_fd;
    logic [15:0] upper;
    drive(ld, b, d, bl);
    div   = kn % SD;
    idx   = (kn / SD) % ND;
    upper = m_shadow >> (4 * idx);
    e_an  = (div < DD) ? 4'b0000 : 4'(1 << idx);
    e_seg = (bl && idx >= 1 && upper == 16'd0) ? 7'd0 : SEGTAB[4'(upper)];
    e_dp  = m_sdp[idx];
    e_fd  = ((kn % FRAME) == FRAME - 1);
    n_an  = ~e_an; n_seg = ~e_seg; n_dp = ~e_dp;
    if (ld && e_fd) begin
      m_shadow = b; m_sdp = d; m_pflag = 1'b0;
    end else if (ld) begin
      m_pend = b; m_pdp = d; m_pflag = 1'b1;
    end else if (e_fd && m_pflag) begin
      m_shadow = m_pend; m_sdp = m_pdp; m_pflag = 1'b0;
    end
    kn++;
    @(posedge clk);
    @(negedge clk);
    obs_seg = bus0.seg; obs_dp = bus0.dp; obs_an = bus0.an; obs_fd = bus0.frame_done;
    chk("an", obs_an, e_an);
    chk("frame_done", obs_fd, e_fd);
    chk("an_lo", bus1.an, n_an);
    if (e_an != 4'b0000) begin
      chk("seg", obs_seg, e_seg);
      chk("dp", obs_dp, e_dp);
      chk("seg_lo", bus1.seg, n_seg);
      chk("dp_lo", bus1.dp, n_dp);
    end
  endtask

  task automatic idle();
    cycle(1'b0, 16'($urandom), 4'($urandom), cur_bl);
  endtask

  task automatic idle_until(input int phase);
    for (int i = 0; i < FRAME && (kn % FRAME) != phase; i++) idle();
  endtask

  task automatic run_expect(input int n, input logic [6:0] es, input string name);
    for (int i = 0; i < n; i++) begin
      idle();
      if (obs_an != 4'b0000) chk(name, obs_seg, es);
    end
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "_an"}, bus0.an, 16'h0);
    chk({name, "_seg"}, bus0.seg, 16'h0);
    chk({name, "_dp"}, bus0.dp, 16'h0);
    chk({name, "_fd"}, bus0.frame_done, 16'h0);
    chk({name, "_an_lo"}, bus1.an, 16'hF);
    chk({name, "_seg_lo"}, bus1.seg, 16'h7F);
    chk({name, "_dp_lo"}, bus1.dp, 16'h1);
  endtask

  initial begin
    logic [6:0] cap_seg [4];
    logic       cap_dp  [4];
    int         dead_cnt, cnt;
    logic [15:0] b, mask;

    tbl[0] = '{16'h1234, 4'b0010, 1'b0, {7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011}, 4'b0010};
    tbl[1] = '{16'h0045, 4'b0000, 1'b1, {7'b0000000, 7'b0000000, 7'b0110011, 7'b1011011}, 4'b0000};
    tbl[2] = '{16'h0000, 4'b0000, 1'b1, {7'b0000000, 7'b0000000, 7'b0000000, 7'b1111110}, 4'b0000};
    tbl[3] = '{16'h9A07, 4'b1001, 1'b0, {7'b1111011, 7'b0000000, 7'b1111110, 7'b1110000}, 4'b1001};
    tbl[4] = '{16'h0008, 4'b0100, 1'b1, {7'b0000000, 7'b0000000, 7'b0000000, 7'b1111111}, 4'b0100};
    tbl[5] = '{16'h5678, 4'b1111, 1'b0, {7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111}, 4'b1111};

    cur_bl = 1'b0;
    drive(1'b0, 16'h0, 4'h0, 1'b0);
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    model_reset();

    // Directed vectors: load, wait for the boundary, then capture one full frame.
    foreach (tbl[t]) begin
      cur_bl = tbl[t].bl;
      cycle(1'b1, tbl[t].bcd, tbl[t].dpv, cur_bl);
      idle_until(0);
      for (int j = 0; j < 4; j++) begin cap_seg[j] = 'x; cap_dp[j] = 1'bx; end
      dead_cnt = 0;
      for (int c = 0; c < FRAME; c++) begin
        idle();
        if (obs_an == 4'b0000) dead_cnt++;
        for (int j = 0; j < 4; j++)
          if (obs_an[j]) begin cap_seg[j] = obs_seg; cap_dp[j] = obs_dp; end
      end
      for (int j = 0; j < 4; j++) begin
        chk($sformatf("tbl%0d_seg%0d", t, j), cap_seg[j], tbl[t].segs[j]);
        chk($sformatf("tbl%0d_dp%0d", t, j), cap_dp[j], tbl[t].dps[j]);
      end
      chk($sformatf("tbl%0d_dead", t), 16'(dead_cnt), 16'(ND * DD));
    end

    // Double load mid-frame, then a load exactly on the boundary edge.
    cur_bl = 1'b0;
    cycle(1'b1, 16'h1111, 4'h0, cur_bl);
    idle_until(0);
    idle_until(10);
    cycle(1'b1, 16'h2222, 4'h0, cur_bl);
    idle_until(20);
    cycle(1'b1, 16'h3333, 4'h0, cur_bl);
    run_expect(FRAME - (kn % FRAME), 7'b0110000, "hold_old");
    run_expect(FRAME - 1, 7'b1111001, "last_load_wins");
    cycle(1'b1, 16'h4444, 4'h0, cur_bl);
    run_expect(FRAME, 7'b0110011, "boundary_load");

    // Reset during the digit-2 slot with a load pending.
    idle_until(17);
    cycle(1'b1, 16'h9999, 4'hF, cur_bl);
    idle();
    chk("pre_reset_an", obs_an, 16'h4);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("async_reset");
    repeat (3) @(negedge clk);
    chk_reset_outputs("held_reset");
    rst_n = 1'b1;
    model_reset();
    cnt = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      idle();
      cnt++;
      if (obs_fd) break;
    end
    chk("fd_after_reset", 16'(cnt), 16'(FRAME));
    run_expect(FRAME, 7'b1111110, "zero_after_reset");

    // Random loads, data and blanking against the model.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 49) == 0) cur_bl = ~cur_bl;
      b = 16'($urandom);
      case ($urandom_range(0, 3))
        0: mask = 16'h000F;
        1: mask = 16'h00FF;
        2: mask = 16'h0FFF;
        default: mask = 16'hFFFF;
      endcase
      if ($urandom_range(0, 1) == 0) b = b & mask;
      cycle(($urandom_range(0, 11) == 0), b, 4'($urandom), cur_bl);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, number of multiplexed digits (legal 1..8).
REQ-002 SHALL have parameter SCAN_DIV, default 1000, clock cycles per digit slot (legal 4..65535).
REQ-003 SHALL have parameter DEAD, default 2, cycles per slot with all digit enables inactive (legal 0..SCAN_DIV-2).
REQ-004 SHALL have parameter ACTIVE_LOW, default 0, which inverts seg, dp and an when 1.
REQ-005 SHALL have port clk  input  1  the single clock; all state is on its rising edge.
REQ-006 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-007 SHALL have port bcd_in  input  4*NUM_DIGITS  BCD digits, digit 0 in bits [3:0] (least significant).
REQ-008 SHALL have port dp_in  input  NUM_DIGITS  decimal point per digit.
REQ-009 SHALL have port load  input  1  single-cycle strobe capturing bcd_in and dp_in.
REQ-010 SHALL have port blank_lz  input  1  enables leading-zero blanking.
REQ-011 SHALL have port seg  output  7  segments a..g, a in bit 6, g in bit 0, registered.
REQ-012 SHALL have port dp  output  1  decimal-point segment, registered.
REQ-013 SHALL have port an  output  NUM_DIGITS  one-hot digit enable, registered.
REQ-014 SHALL have port frame_done  output  1  one-cycle pulse at the end of each full scan.

Function
REQ-015 Slot counter div SHALL count 0..SCAN_DIV-1 and wrap. Digit index idx SHALL advance when div=SCAN_DIV-1, wrapping from NUM_DIGITS-1 to 0.
REQ-016 Decode (active-high) SHALL be 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011. Codes 10..15 SHALL decode to 0000000.
REQ-017 On load, bcd_in/dp_in SHALL go to a pending register and set a pending flag. Display (shadow) data SHALL change only at a frame boundary: the cycle with div=SCAN_DIV-1 and idx=NUM_DIGITS-1.
REQ-018 At a frame boundary with the pending flag set, shadow SHALL take the pending data and the flag SHALL clear. If load coincides with the boundary, shadow SHALL take bcd_in/dp_in directly and the flag SHALL stay clear.
REQ-019 A second load before the boundary SHALL overwrite the pending data (last load wins).
REQ-020 Outputs SHALL lag one cycle from div/idx: for div<DEAD, an SHALL be all inactive. Otherwise an[idx] SHALL be active, seg SHALL be decode(shadow[idx]) and dp SHALL be shadow dp[idx].
REQ-021 With blank_lz=1, digit i≥1 SHALL show seg=0000000 while shadow digits NUM_DIGITS-1..i are all zero. Its dp SHALL still follow dp_in. Digit 0 SHALL never be blanked.
REQ-022 frame_done SHALL be high exactly the cycle after each frame boundary, once per NUM_DIGITS*SCAN_DIV cycles.
REQ-023 With NUM_DIGITS=1, idx SHALL stay 0 and every slot end SHALL be a frame boundary.

Reset
REQ-024 While rst_n=0: div=0, idx=0, shadow=0, pending data=0, pending flag=0, frame_done=0, an all inactive, seg and dp off (polarity per ACTIVE_LOW).
REQ-025 Reset deasserted mid-frame SHALL restart scanning at idx=0, div=0. Any unapplied load SHALL be lost.

Structure
REQ-026 Segment pattern constants and the blank pattern SHALL live in shared package seg7_pkg.
REQ-027 Per-digit decode SHALL be the sub-module seg7_digit_decode (4-bit in, 7-bit active-high out), instantiated once on the selected digit. The polarity inversion SHALL be applied after it.

Verification
REQ-028 Setup NUM_DIGITS=4, SCAN_DIV=8, DEAD=2; load 0x1234 with dp_in=0010 -> digit 3 shows 0110000, digit 0 shows 0110011, dp is active only in digit-1 slots, and an is inactive for 2 of every 8 cycles.
REQ-029 Load 0x0045 with blank_lz=1 -> digits 3,2 show 0000000 and digits 1,0 show 4,5. Load 0x0000 -> only digit 0 lit, showing 1111110.
REQ-030 Load mid-frame, then a second load before the boundary -> display unchanged until the boundary, then shows the second value. A load in the exact boundary cycle -> value shown from the next frame.
REQ-031 Load digit value 0xA -> that slot shows 0000000. ACTIVE_LOW=1 -> seg, dp and an are the bitwise complement of the ACTIVE_LOW=0 run.
REQ-032 Assert rst_n=0 during the idx=2 slot with a load pending -> outputs go to the reset state immediately. After release, frame_done first pulses 32 cycles later and the display shows zeros.
